// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings,
// transaction owner encoding and the "no write" byte-enable constant.
package mem_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_FB   = 1'b1
  } owner_t;

  localparam logic [1:0] WREN_NONE = 2'b00;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the MEM stage, the frame-buffer DMA, the arbiter and
// the memory I/O unit. The slave modport is the arbiter's view; the master
// modport is the view of everything around it (requesters plus memory).
interface mem_port_arbiter_if;

  logic        pipe_req;
  logic [1:0]  pipe_wren;
  logic [16:0] pipe_addr;
  logic [7:0]  pipe_wdata_top;
  logic [7:0]  pipe_wdata_bot;
  logic        pipe_ack;
  logic        pipe_stall;

  logic        fb_req;
  logic [16:0] fb_addr;
  logic        fb_ack;

  logic [7:0]  rdata_top;
  logic [7:0]  rdata_bot;

  logic [16:0] address;
  logic [1:0]  mem_wren;
  logic [7:0]  mem_write_data_top;
  logic [7:0]  mem_write_data_bot;
  logic [7:0]  mem_read_data_top;
  logic [7:0]  mem_read_data_bot;

  modport slave (
    input  pipe_req, pipe_wren, pipe_addr, pipe_wdata_top, pipe_wdata_bot,
    input  fb_req, fb_addr,
    input  mem_read_data_top, mem_read_data_bot,
    output pipe_ack, pipe_stall, fb_ack, rdata_top, rdata_bot,
    output address, mem_wren, mem_write_data_top, mem_write_data_bot
  );

  modport master (
    output pipe_req, pipe_wren, pipe_addr, pipe_wdata_top, pipe_wdata_bot,
    output fb_req, fb_addr,
    output mem_read_data_top, mem_read_data_bot,
    input  pipe_ack, pipe_stall, fb_ack, rdata_top, rdata_bot,
    input  address, mem_wren, mem_write_data_top, mem_write_data_bot
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating starvation counter for the frame-buffer requester. Counts pipe
// grants made while the DMA is waiting; at_limit forces the next grant to fb.
// Only instantiated when MEM_ARB_FAIRNESS_EN is defined.
module mem_arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic nreset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] LIMIT = W'(MAX);

  logic [W-1:0] count;

  // Clear has priority over increment; the count saturates at LIMIT.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single memory I/O port shared by the MEM pipeline stage
// and the frame-buffer scan-out DMA. Fixed pipe priority by default; define
// MEM_ARB_FAIRNESS_EN to bound how long the DMA can be starved.
// Each access: one arbitration cycle, MEM_LAT held cycles, one ack cycle.
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int MEM_LAT     = 2,
  parameter int FB_MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              nreset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] cnt;
  logic [16:0]      address;
  logic [1:0]       mem_wren;
  logic [7:0]       wdata_top;
  logic [7:0]       wdata_bot;
  logic [7:0]       rdata_top;
  logic [7:0]       rdata_bot;
  logic             pipe_ack;
  logic             fb_ack;

  logic grant_fb;
  logic grant_pipe;

`ifdef MEM_ARB_FAIRNESS_EN
  logic starve_at_limit;
  logic starve_inc;
  logic starve_clr;

  // The DMA wins when the pipe is idle or when it has waited long enough.
  always_comb begin
    grant_fb   = bus.fb_req & (~bus.pipe_req | starve_at_limit);
    grant_pipe = bus.pipe_req & ~grant_fb;
  end

  // Starvation counting only happens at arbitration time.
  always_comb begin
    starve_inc = (state == ST_IDLE) & grant_pipe & bus.fb_req;
    starve_clr = (state == ST_IDLE) & (grant_fb | ~bus.fb_req);
  end

  mem_arb_starve_ctr #(
    .MAX (FB_MAX_WAIT)
  ) u_starve_ctr (
    .clock    (clock),
    .nreset   (nreset),
    .clr      (starve_clr),
    .inc      (starve_inc),
    .at_limit (starve_at_limit)
  );
`else
  // Strict pipe priority: the DMA only gets the port when the pipe is quiet.
  always_comb begin
    grant_fb   = bus.fb_req & ~bus.pipe_req;
    grant_pipe = bus.pipe_req;
  end
`endif

  // Arbitration FSM: grants in IDLE, holds the access for MEM_LAT cycles in
  // BUSY, then issues a single ack in DONE before re-arbitrating.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      owner     <= OWN_PIPE;
      cnt       <= '0;
      address   <= 17'd0;
      mem_wren  <= WREN_NONE;
      wdata_top <= 8'd0;
      wdata_bot <= 8'd0;
      rdata_top <= 8'd0;
      rdata_bot <= 8'd0;
      pipe_ack  <= 1'b0;
      fb_ack    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pipe_ack <= 1'b0;
          fb_ack   <= 1'b0;
          cnt      <= '0;
          if (grant_pipe) begin
            state     <= ST_BUSY;
            owner     <= OWN_PIPE;
            address   <= bus.pipe_addr;
            mem_wren  <= bus.pipe_wren;
            wdata_top <= bus.pipe_wdata_top;
            wdata_bot <= bus.pipe_wdata_bot;
          end else if (grant_fb) begin
            state     <= ST_BUSY;
            owner     <= OWN_FB;
            address   <= bus.fb_addr;
            mem_wren  <= WREN_NONE;
            wdata_top <= 8'd0;
            wdata_bot <= 8'd0;
          end else begin
            state     <= ST_IDLE;
            address   <= 17'd0;
            mem_wren  <= WREN_NONE;
            wdata_top <= 8'd0;
            wdata_bot <= 8'd0;
          end
        end
        ST_BUSY: begin
          // A write is a single pulse in the first held cycle.
          mem_wren <= WREN_NONE;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state     <= ST_DONE;
            rdata_top <= bus.mem_read_data_top;
            rdata_bot <= bus.mem_read_data_bot;
            address   <= 17'd0;
            wdata_top <= 8'd0;
            wdata_bot <= 8'd0;
            pipe_ack  <= (owner == OWN_PIPE);
            fb_ack    <= (owner == OWN_FB);
          end else begin
            state <= ST_BUSY;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          pipe_ack <= 1'b0;
          fb_ack   <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          address  <= 17'd0;
          mem_wren <= WREN_NONE;
          pipe_ack <= 1'b0;
          fb_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.address            = address;
  assign bus.mem_wren           = mem_wren;
  assign bus.mem_write_data_top = wdata_top;
  assign bus.mem_write_data_bot = wdata_bot;
  assign bus.rdata_top          = rdata_top;
  assign bus.rdata_bot          = rdata_bot;
  assign bus.pipe_ack           = pipe_ack;
  assign bus.fb_ack             = fb_ack;
  // Stall stays combinational so the pipeline releases in the ack cycle.
  assign bus.pipe_stall         = bus.pipe_req & ~pipe_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, FB_MAX_WAIT=4.
module tb_mem_port_arbiter;

  localparam int MEM_LAT     = 2;
  localparam int FB_MAX_WAIT = 4;

  logic clock;
  logic nreset;
  int   n_cmp;
  int   n_fail;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_LAT     (MEM_LAT),
    .FB_MAX_WAIT (FB_MAX_WAIT)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  wren;
    logic [16:0] addr;
    logic [7:0]  wd_top;
    logic [7:0]  wd_bot;
    logic [7:0]  mrd_top;
    logic [7:0]  mrd_bot;
    logic [7:0]  exp_top;
    logic [7:0]  exp_bot;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One pipe transaction checked cycle by cycle; requester drops req in the ack cycle.
  task automatic do_pipe(input vec_t v, input string tag);
    bus.pipe_req          = 1'b1;
    bus.pipe_wren         = v.wren;
    bus.pipe_addr         = v.addr;
    bus.pipe_wdata_top    = v.wd_top;
    bus.pipe_wdata_bot    = v.wd_bot;
    bus.mem_read_data_top = v.mrd_top;
    bus.mem_read_data_bot = v.mrd_bot;
    #1;
    chk({tag, "_c1_stall"}, 32'(bus.pipe_stall), 32'd1);
    chk({tag, "_c1_addr"}, 32'(bus.address), 32'd0);
    chk({tag, "_c1_ack"}, 32'(bus.pipe_ack), 32'd0);
    for (int k = 0; k < MEM_LAT; k++) begin
      step();
      #1;
      chk($sformatf("%s_b%0d_addr", tag, k), 32'(bus.address), 32'(v.addr));
      chk($sformatf("%s_b%0d_wdt", tag, k), 32'(bus.mem_write_data_top), 32'(v.wd_top));
      chk($sformatf("%s_b%0d_wdb", tag, k), 32'(bus.mem_write_data_bot), 32'(v.wd_bot));
      chk($sformatf("%s_b%0d_wren", tag, k), 32'(bus.mem_wren), (k == 0) ? 32'(v.wren) : 32'd0);
      chk($sformatf("%s_b%0d_stall", tag, k), 32'(bus.pipe_stall), 32'd1);
      chk($sformatf("%s_b%0d_ack", tag, k), 32'(bus.pipe_ack), 32'd0);
    end
    step();
    #1;
    chk({tag, "_ack"}, 32'(bus.pipe_ack), 32'd1);
    chk({tag, "_ack_stall"}, 32'(bus.pipe_stall), 32'd0);
    chk({tag, "_ack_fback"}, 32'(bus.fb_ack), 32'd0);
    chk({tag, "_ack_addr"}, 32'(bus.address), 32'd0);
    chk({tag, "_ack_wren"}, 32'(bus.mem_wren), 32'd0);
    chk({tag, "_rd_top"}, 32'(bus.rdata_top), 32'(v.exp_top));
    chk({tag, "_rd_bot"}, 32'(bus.rdata_bot), 32'(v.exp_bot));
    bus.pipe_req  = 1'b0;
    bus.pipe_wren = 2'b00;
    step();
    #1;
    chk({tag, "_post_ack"}, 32'(bus.pipe_ack), 32'd0);
    chk({tag, "_post_stall"}, 32'(bus.pipe_stall), 32'd0);
  endtask

  initial begin
    int pa;
    int fa;
    int wren_cycles;
    int fb_addr_cycles;
    int p_acks;
    int f_acks;
    int bad_pos;
    int prev_ack;

    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{2'b00, 17'h1ABCD, 8'h00, 8'h00, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[1] = '{2'b10, 17'h00123, 8'h77, 8'h00, 8'h11, 8'h22, 8'h11, 8'h22};
    vecs[2] = '{2'b01, 17'h0F0F0, 8'h00, 8'hA5, 8'h33, 8'h44, 8'h33, 8'h44};
    vecs[3] = '{2'b11, 17'h1FFFF, 8'hDE, 8'hAD, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[4] = '{2'b00, 17'h00000, 8'h00, 8'h00, 8'h81, 8'h7E, 8'h81, 8'h7E};

    nreset                = 1'b0;
    bus.pipe_req          = 1'b0;
    bus.pipe_wren         = 2'b00;
    bus.pipe_addr         = 17'd0;
    bus.pipe_wdata_top    = 8'd0;
    bus.pipe_wdata_bot    = 8'd0;
    bus.fb_req            = 1'b0;
    bus.fb_addr           = 17'd0;
    bus.mem_read_data_top = 8'd0;
    bus.mem_read_data_bot = 8'd0;

    // Reset state
    step();
    step();
    chk("rst_addr", 32'(bus.address), 32'd0);
    chk("rst_wren", 32'(bus.mem_wren), 32'd0);
    chk("rst_pipe_ack", 32'(bus.pipe_ack), 32'd0);
    chk("rst_fb_ack", 32'(bus.fb_ack), 32'd0);
    chk("rst_rdata", 32'({bus.rdata_top, bus.rdata_bot}), 32'd0);
    chk("rst_stall", 32'(bus.pipe_stall), 32'd0);
    nreset = 1'b1;
    step();

    // Table-driven single pipe accesses
    for (int i = 0; i < 5; i++) begin
      do_pipe(vecs[i], $sformatf("v%0d", i));
    end

    // Simultaneous pipe write and fb read: pipe first, fb ack four cycles later
    pa = 0; fa = 0; wren_cycles = 0; fb_addr_cycles = 0;
    bus.pipe_req       = 1'b1;
    bus.pipe_wren      = 2'b11;
    bus.pipe_addr      = 17'h00AAA;
    bus.pipe_wdata_top = 8'h12;
    bus.pipe_wdata_bot = 8'h34;
    bus.fb_req         = 1'b1;
    bus.fb_addr        = 17'h15555;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (bus.mem_wren != 2'b00) wren_cycles++;
      if (c > 4 && bus.address == 17'h15555) fb_addr_cycles++;
      if (bus.pipe_ack) begin
        if (pa == 0) pa = c;
        bus.pipe_req  = 1'b0;
        bus.pipe_wren = 2'b00;
      end
      if (bus.fb_ack) begin
        if (fa == 0) fa = c;
        bus.fb_req = 1'b0;
      end
      step();
    end
    chk("both_pipe_ack_cycle", 32'(pa), 32'd4);
    chk("both_fb_ack_cycle", 32'(fa), 32'd8);
    chk("both_wren_cycles", 32'(wren_cycles), 32'd1);
    chk("both_fb_addr_cycles", 32'(fb_addr_cycles), 32'd2);

    // Async reset during the first BUSY cycle of a write
    bus.pipe_req       = 1'b1;
    bus.pipe_wren      = 2'b11;
    bus.pipe_addr      = 17'h0BEEF;
    bus.pipe_wdata_top = 8'h99;
    bus.pipe_wdata_bot = 8'h66;
    step();
    #1;
    chk("arst_pre_wren", 32'(bus.mem_wren), 32'd3);
    nreset = 1'b0;
    #1;
    chk("arst_wren", 32'(bus.mem_wren), 32'd0);
    chk("arst_addr", 32'(bus.address), 32'd0);
    chk("arst_acks", 32'({bus.pipe_ack, bus.fb_ack}), 32'd0);
    bus.pipe_req  = 1'b0;
    bus.pipe_wren = 2'b00;
    step();
    nreset = 1'b1;
    step();
    do_pipe(vecs[0], "arst_after");

`ifdef MEM_ARB_FAIRNESS_EN
    // Fairness: with both requesting, order must be P,P,P,P,F,P
    begin
      logic [5:0] order;
      int n;
      n = 0;
      order = 6'd0;
      bus.pipe_req = 1'b1;
      bus.fb_req   = 1'b1;
      bus.fb_addr  = 17'h00F00;
      for (int c = 1; c <= 40 && n < 6; c++) begin
        #1;
        if (bus.pipe_ack) begin
          order[n] = 1'b0;
          n++;
        end else if (bus.fb_ack) begin
          order[n] = 1'b1;
          n++;
          bus.fb_req = 1'b0;
        end
        step();
      end
      chk("fair_ack_count", 32'(n), 32'd6);
      chk("fair_order", 32'(order), 32'(6'b010000));
      bus.pipe_req = 1'b0;
      bus.fb_req   = 1'b0;
      step();
      step();
      step();
    end
`else
    // Strict priority: pipe held high starves fb for 100 cycles; one ack per access
    p_acks = 0; f_acks = 0; bad_pos = 0; prev_ack = 0;
    bus.pipe_req  = 1'b1;
    bus.pipe_wren = 2'b00;
    bus.fb_req    = 1'b1;
    bus.fb_addr   = 17'h00F00;
    for (int c = 1; c <= 100; c++) begin
      #1;
      if (bus.pipe_ack) begin
        p_acks++;
        if ((c % 4) != 0 || prev_ack != 0) bad_pos++;
      end
      if (bus.fb_ack) f_acks++;
      prev_ack = int'(bus.pipe_ack);
      step();
    end
    chk("starve_fb_acks", 32'(f_acks), 32'd0);
    chk("held_pipe_acks", 32'(p_acks), 32'd25);
    chk("held_ack_position", 32'(bad_pos), 32'd0);
    bus.pipe_req = 1'b0;
    bus.fb_req   = 1'b0;
    step();
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
